// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and defaults for the uart tx arbiter
package uart_pkg;

  localparam int DEFAULT_DATA_SIZE = 8;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
module rr_pick
  import uart_pkg::*;
#(
  parameter int NumRequesters = 2
) (
  input  logic [NumRequesters-1:0]         req,
  input  logic [$clog2(NumRequesters)-1:0] ptr,
  output logic [NumRequesters-1:0]         grant,
  output logic                             any
);

  localparam int PtrW = $clog2(NumRequesters);

  logic [PtrW-1:0] idx;
  logic            found;

  // Search upward from the slot after the last owner, wrapping, first request wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NumRequesters; i++) begin
      idx = PtrW'((int'(ptr) + i) % NumRequesters);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin sharing of the uart tx byte stream
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumRequesters = 2,
  parameter int DataSize      = DEFAULT_DATA_SIZE,
  parameter int IdleTimeout   = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NumRequesters-1:0]          i_req_valid,
  input  logic [NumRequesters*DataSize-1:0] i_req_data,
  input  logic [NumRequesters-1:0]          i_req_last,
  output logic [NumRequesters-1:0]          o_req_ready,
  output logic                              o_tx_valid,
  output logic [DataSize-1:0]               o_tx_data,
  input  logic                              i_tx_ready,
  output logic [NumRequesters-1:0]          o_grant,
  output logic                              o_busy,
  output logic                              o_timeout
);

  localparam int PtrW = $clog2(NumRequesters);
  localparam int CntW = (IdleTimeout > 0) ? $clog2(IdleTimeout + 1) : 1;
  localparam bit WdEn = (IdleTimeout > 0);
  localparam logic [CntW-1:0] CntLast = (IdleTimeout > 0) ? CntW'(IdleTimeout - 1) : '0;
  localparam logic [CntW-1:0] CntMax  = '1;

  arb_state_e          state;
  logic [PtrW-1:0]     owner;
  logic [PtrW-1:0]     ptr;
  logic [CntW-1:0]     idle_cnt;

  logic [NumRequesters-1:0] pick_grant;
  logic                     pick_any;
  logic [PtrW-1:0]          pick_idx;
  logic                     own_last;
  logic                     xfer;
  logic                     wd_hit;

  rr_pick #(
    .NumRequesters(NumRequesters)
  ) u_rr_pick (
    .req  (i_req_valid),
    .ptr  (ptr),
    .grant(pick_grant),
    .any  (pick_any)
  );

  // Encode the one-hot winner so the owner can be stored as an index
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      if (pick_grant[k]) pick_idx = PtrW'(k);
    end
  end

  // Pass the owner's stream straight through while locked; everything else stays quiet
  always_comb begin
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    o_req_ready = '0;
    own_last    = 1'b0;
    if (state == ARB_LOCKED) begin
      for (int k = 0; k < NumRequesters; k++) begin
        if (owner == PtrW'(k)) begin
          o_tx_valid     = i_req_valid[k];
          o_tx_data      = i_req_data[k*DataSize +: DataSize];
          own_last       = i_req_last[k];
          o_req_ready[k] = i_tx_ready;
        end
      end
    end
  end

  assign xfer   = o_tx_valid & i_tx_ready;
  // Only an owner with valid low ages the counter, so uart backpressure can never expire it
  assign wd_hit = WdEn && (state == ARB_LOCKED) && !o_tx_valid && (idle_cnt == CntLast);

  // Arbitration / lock FSM with idle watchdog and registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      ptr       <= PtrW'(NumRequesters - 1);
      idle_cnt  <= '0;
      o_grant   <= '0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state    <= ARB_LOCKED;
            owner    <= pick_idx;
            o_grant  <= pick_grant;
            o_busy   <= 1'b1;
            idle_cnt <= '0;
          end
        end
        ARB_LOCKED: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (own_last) begin
              state   <= ARB_IDLE;
              ptr     <= owner;
              o_grant <= '0;
              o_busy  <= 1'b0;
            end
          end else if (wd_hit) begin
            state     <= ARB_IDLE;
            ptr       <= owner;
            o_grant   <= '0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
            idle_cnt  <= '0;
          end else if (!o_tx_valid && (idle_cnt != CntMax)) begin
            idle_cnt <= idle_cnt + CntW'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct packed { logic [7:0] d; logic l; } src_t;
  typedef struct packed { logic [7:0] d; logic [1:0] g; } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout;

  src_t src_q[2][$];
  exp_t exp_q[$];
  int   xfer_cyc[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic [1:0] fire = '0;
  bit   toggle0 = 1'b0;

  uart_tx_arbiter #(
    .NumRequesters(N),
    .DataSize     (DW),
    .IdleTimeout  (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(req_valid),
    .i_req_data (req_data),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .o_grant    (grant),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic src_push(input int k, input logic [7:0] d, input logic l);
    src_t s;
    s.d = d;
    s.l = l;
    src_q[k].push_back(s);
  endtask

  task automatic exp_push(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.d = d;
    e.g = g;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"},    32'(grant),     32'd0);
    check({tag, "_busy"},     32'(busy),      32'd0);
    check({tag, "_timeout"},  32'(timeout),   32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid),  32'd0);
    check({tag, "_tx_data"},  32'(tx_data),   32'd0);
    check({tag, "_ready"},    32'(req_ready), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    toggle0 = 1'b0;
    src_q[0].delete();
    src_q[1].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    xfer_cyc.delete();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Requester models: pop on a sampled handshake, then present the next queued byte
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (k == 0 && toggle0) begin
          req_valid[0]  = ~req_valid[0];
          req_data[7:0] = 8'($urandom);
          req_last[0]   = 1'($urandom);
        end else if (src_q[k].size() > 0) begin
          req_valid[k]          = 1'b1;
          req_data[k*DW +: DW]  = src_q[k][0].d;
          req_last[k]           = src_q[k][0].l;
        end else begin
          req_valid[k]          = 1'b0;
          req_data[k*DW +: DW]  = '0;
          req_last[k]           = 1'b0;
        end
      end
    end
  end

  // Monitor: every uart-side transfer is checked against the next expected byte
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      if (tx_valid && tx_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tx: got byte 0x%0h grant %b, expected no transfer", tx_data, grant);
        end else begin
          e = exp_q.pop_front();
          check("tx_data",  32'(tx_data), 32'(e.d));
          check("tx_grant", 32'(grant),   32'(e.g));
        end
      end
      if (toggle0 && grant == 2'b10) check("nonowner_ready0", 32'(req_ready[0]), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int bad_to;
    int bad_rdy;
    int rdy_cyc;

    rst      = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("rst");

    // 1: two 3-byte packets, req0 first, one idle cycle between packets
    do_reset();
    src_push(0, 8'hA0, 1'b0); src_push(0, 8'hA1, 1'b0); src_push(0, 8'hA2, 1'b1);
    src_push(1, 8'hB0, 1'b0); src_push(1, 8'hB1, 1'b0); src_push(1, 8'hB2, 1'b1);
    exp_push(8'hA0, 2'b01); exp_push(8'hA1, 2'b01); exp_push(8'hA2, 2'b01);
    exp_push(8'hB0, 2'b10); exp_push(8'hB1, 2'b10); exp_push(8'hB2, 2'b10);
    wait_drain("t1_drain");
    check("t1_xfer_count", 32'(xfer_cyc.size()), 32'd6);
    if (xfer_cyc.size() >= 4) begin
      check("t1_back_to_back_a", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);
      check("t1_back_to_back_b", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd1);
      check("t1_bubble",         32'(xfer_cyc[3] - xfer_cyc[2]), 32'd2);
    end

    // 2: fairness with 1-byte packets, grants alternate while both pend
    do_reset();
    for (int i = 0; i < 4; i++) src_push(0, 8'(i), 1'b1);
    for (int i = 0; i < 3; i++) src_push(1, 8'(8'h10 + i), 1'b1);
    exp_push(8'h00, 2'b01); exp_push(8'h10, 2'b10);
    exp_push(8'h01, 2'b01); exp_push(8'h11, 2'b10);
    exp_push(8'h02, 2'b01); exp_push(8'h12, 2'b10);
    exp_push(8'h03, 2'b01);
    wait_drain("t2_drain");

    // 3: long uart backpressure (far beyond the idle timeout) must never release
    do_reset();
    tx_ready = 1'b0;
    src_push(0, 8'h5A, 1'b1);
    exp_push(8'h5A, 2'b01);
    bad_to  = 0;
    bad_rdy = 0;
    repeat (5000) begin
      @(negedge clk);
      if (timeout) bad_to++;
      if (req_ready[0]) bad_rdy++;
    end
    check("bp_no_timeout", 32'(bad_to),   32'd0);
    check("bp_ready_low",  32'(bad_rdy),  32'd0);
    check("bp_busy",       32'(busy),     32'd1);
    check("bp_tx_valid",   32'(tx_valid), 32'd1);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    rdy_cyc = cyc;
    wait_drain("bp_drain");
    check("bp_first_ready_xfer", 32'((xfer_cyc.size() > 0) ? xfer_cyc[0] : -1), 32'(rdy_cyc));

    // 4: watchdog; 16 valid-low cycles after the transfer, pulse on the next one
    do_reset();
    src_push(0, 8'h11, 1'b0);
    src_push(1, 8'hC1, 1'b1);
    exp_push(8'h11, 2'b01);
    exp_push(8'hC1, 2'b10);
    n = 0;
    while (!timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wd_pulse_seen", 32'(timeout), 32'd1);
    check("wd_delay", 32'((xfer_cyc.size() > 0) ? (cyc - xfer_cyc[0]) : -1), 32'd17);
    check("wd_busy_low",  32'(busy),  32'd0);
    check("wd_grant_low", 32'(grant), 32'd0);
    @(negedge clk);
    check("wd_pulse_one_cycle", 32'(timeout), 32'd0);
    check("wd_next_grant",      32'(grant),   32'd2);
    check("wd_next_busy",       32'(busy),    32'd1);
    wait_drain("wd_drain");

    // 5: req1 locked, req0 chatters, only req1 bytes may reach the uart
    do_reset();
    for (int i = 0; i < 8; i++) begin
      src_push(1, 8'(8'h20 + i), (i == 7));
      exp_push(8'(8'h20 + i), 2'b10);
    end
    n = 0;
    while (grant != 2'b10 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("iso_lock_r1", 32'(grant), 32'd2);
    @(posedge clk);
    #1 toggle0 = 1'b1;
    repeat (4) @(posedge clk);
    #1 toggle0 = 1'b0;
    wait_drain("iso_drain");

    // 6: reset after 2 of 4 bytes aborts; afterwards req0 has priority again
    do_reset();
    src_push(0, 8'hD0, 1'b0); src_push(0, 8'hD1, 1'b0);
    src_push(0, 8'hD2, 1'b0); src_push(0, 8'hD3, 1'b1);
    exp_push(8'hD0, 2'b01); exp_push(8'hD1, 2'b01);
    n = 0;
    while (xfer_cyc.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_two_sent", 32'(xfer_cyc.size()), 32'd2);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    tx_ready = 1'b0;
    src_q[0].delete();
    src_q[1].delete();
    @(negedge clk);
    @(negedge clk);
    check_idle("mid_rst");
    @(posedge clk);
    #1;
    rst      = 1'b0;
    tx_ready = 1'b1;
    exp_q.delete();
    src_push(1, 8'hF0, 1'b1);
    src_push(0, 8'hE0, 1'b1);
    exp_push(8'hE0, 2'b01);
    exp_push(8'hF0, 2'b10);
    wait_drain("mid_after_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
